// File: rtl/ex_forward_stage.sv
// Execute/forwarding stage: forward muxes, ALU, data-memory drive and the
// three-deep result history (alu_q -> mem_q -> wb_q) that the forwarding selects index into.
module ex_forward_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_dec,
    input  logic [WIDTH-1:0] imm,
    input  logic             imm_sel,
    input  logic [1:0]       mux_sel_A,
    input  logic [1:0]       mux_sel_B,
    input  logic [WIDTH-1:0] rf_data_A,
    input  logic [WIDTH-1:0] rf_data_B,
    input  logic             mem_en_ex,
    input  logic             mem_rw_ex,
    input  logic             mem_mux_sel_dm,
    input  logic [WIDTH-1:0] dm_rdata,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    output logic             dm_en,
    output logic             dm_rw,
    output logic [WIDTH-1:0] alu_q,
    output logic [WIDTH-1:0] wb_data,
    output logic             zero_flag
);

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_NOT = 3'b101,
        FN_SHL = 3'b110,
        FN_ASR = 3'b111
    } alu_fn_t;

    logic [WIDTH-1:0] st_q;
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] wb_q;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    alu_fn_t          alu_fn;

    // Forward muxes read only registered history, so there is no path from the live ALU output back to its inputs.
    always_comb begin
        op_a = rf_data_A;
        unique case (mux_sel_A)
            2'b00: op_a = rf_data_A;
            2'b01: op_a = alu_q;
            2'b10: op_a = mem_q;
            2'b11: op_a = wb_q;
        endcase

        fwd_b = rf_data_B;
        unique case (mux_sel_B)
            2'b00: fwd_b = rf_data_B;
            2'b01: fwd_b = alu_q;
            2'b10: fwd_b = mem_q;
            2'b11: fwd_b = wb_q;
        endcase

        op_b = imm_sel ? imm : fwd_b;
    end

    // Load/store/jump class always computes an address with ADD.
    always_comb begin
        alu_fn = (op_dec[5:4] == 2'b01) ? FN_ADD : alu_fn_t'(op_dec[2:0]);
        alu_result = '0;
        unique case (alu_fn)
            FN_ADD: alu_result = op_a + op_b;
            FN_SUB: alu_result = op_a - op_b;
            FN_AND: alu_result = op_a & op_b;
            FN_OR:  alu_result = op_a | op_b;
            FN_XOR: alu_result = op_a ^ op_b;
            FN_NOT: alu_result = ~op_a;
            FN_SHL: alu_result = op_a << op_b[3:0];
            FN_ASR: alu_result = WIDTH'($signed(op_a) >>> op_b[3:0]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_q     <= '0;
            st_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            zero_flag <= 1'b0;
        end else begin
            alu_q <= alu_result;
            st_q  <= fwd_b;
            mem_q <= mem_mux_sel_dm ? dm_rdata : alu_q;
            wb_q  <= mem_q;
            if (op_dec[5:4] == 2'b00) begin
                zero_flag <= (alu_result == '0);
            end
        end
    end

    assign dm_addr  = alu_q;
    assign dm_wdata = st_q;
    assign dm_en    = mem_en_ex & reset;
    assign dm_rw    = mem_rw_ex & reset;
    assign wb_data  = mem_q;

endmodule

// File: tb/tb_ex_forward_stage.sv
// Directed bench for ex_forward_stage: an ALU vector table plus hand-written
// sequences for reset, forwarding distances, load and store.
module tb_ex_forward_stage;

    logic        clk;
    logic        reset;
    logic [5:0]  op_dec;
    logic [15:0] imm;
    logic        imm_sel;
    logic [1:0]  mux_sel_A;
    logic [1:0]  mux_sel_B;
    logic [15:0] rf_data_A;
    logic [15:0] rf_data_B;
    logic        mem_en_ex;
    logic        mem_rw_ex;
    logic        mem_mux_sel_dm;
    logic [15:0] dm_rdata;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_en;
    logic        dm_rw;
    logic [15:0] alu_q;
    logic [15:0] wb_data;
    logic        zero_flag;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        imm_sel;
        logic [15:0] exp_alu;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[14];

    ex_forward_stage #(.WIDTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .op_dec(op_dec),
        .imm(imm),
        .imm_sel(imm_sel),
        .mux_sel_A(mux_sel_A),
        .mux_sel_B(mux_sel_B),
        .rf_data_A(rf_data_A),
        .rf_data_B(rf_data_B),
        .mem_en_ex(mem_en_ex),
        .mem_rw_ex(mem_rw_ex),
        .mem_mux_sel_dm(mem_mux_sel_dm),
        .dm_rdata(dm_rdata),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_en(dm_en),
        .dm_rw(dm_rw),
        .alu_q(alu_q),
        .wb_data(wb_data),
        .zero_flag(zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        op_dec    = v.op;
        rf_data_A = v.a;
        rf_data_B = v.b;
        imm       = v.imm;
        imm_sel   = v.imm_sel;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 16'h0003, 16'h0005, 16'h0000, 1'b0, 16'h0008, 1'b0};
        vecs[1]  = '{6'b000001, 16'h0005, 16'h0007, 16'h0000, 1'b0, 16'hFFFE, 1'b0};
        vecs[2]  = '{6'b000010, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 16'h3030, 1'b0};
        vecs[3]  = '{6'b000011, 16'hF000, 16'h000F, 16'h0000, 1'b0, 16'hF00F, 1'b0};
        vecs[4]  = '{6'b000100, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[5]  = '{6'b010011, 16'h0010, 16'h9999, 16'h0004, 1'b1, 16'h0014, 1'b1};
        vecs[6]  = '{6'b000101, 16'h00FF, 16'h1234, 16'h0000, 1'b0, 16'hFF00, 1'b0};
        vecs[7]  = '{6'b100001, 16'h0010, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{6'b000110, 16'h0001, 16'h0013, 16'h0000, 1'b0, 16'h0008, 1'b0};
        vecs[9]  = '{6'b000111, 16'h8000, 16'h0004, 16'h0000, 1'b0, 16'hF800, 1'b0};
        vecs[10] = '{6'b000111, 16'h4000, 16'h0001, 16'h0000, 1'b0, 16'h2000, 1'b0};
        vecs[11] = '{6'b001000, 16'h8000, 16'h5555, 16'h8000, 1'b1, 16'h0000, 1'b1};
        vecs[12] = '{6'b110011, 16'h1200, 16'h0034, 16'h0000, 1'b0, 16'h1234, 1'b1};
        vecs[13] = '{6'b001111, 16'h8000, 16'h7777, 16'h0004, 1'b1, 16'hF800, 1'b0};

        // Reset held for two edges with live inputs and memory requests.
        reset = 1'b0;
        op_dec = 6'b000000; rf_data_A = 16'h1111; rf_data_B = 16'h2222;
        imm = 16'h3333; imm_sel = 1'b0; mux_sel_A = 2'b00; mux_sel_B = 2'b00;
        mem_en_ex = 1'b1; mem_rw_ex = 1'b1; mem_mux_sel_dm = 1'b1; dm_rdata = 16'hDEAD;
        #1;
        checkOutput("rst_dm_en_pre", {15'b0, dm_en}, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_dm_en", {15'b0, dm_en}, 16'h0000);
            checkOutput("rst_dm_rw", {15'b0, dm_rw}, 16'h0000);
            checkOutput("rst_alu_q", alu_q, 16'h0000);
            checkOutput("rst_wb_data", wb_data, 16'h0000);
            checkOutput("rst_dm_wdata", dm_wdata, 16'h0000);
            checkOutput("rst_zero", {15'b0, zero_flag}, 16'h0000);
        end

        // Release reset and issue the register ADD.
        reset = 1'b1;
        mem_mux_sel_dm = 1'b0;
        rf_data_A = 16'h0003; rf_data_B = 16'h0005;
        #1;
        checkOutput("rel_dm_en", {15'b0, dm_en}, 16'h0001);
        mem_en_ex = 1'b0; mem_rw_ex = 1'b0;
        tick();
        checkOutput("add_alu_q", alu_q, 16'h0008);
        checkOutput("add_zero", {15'b0, zero_flag}, 16'h0000);

        // SUB with A forwarded from alu_q.
        op_dec = 6'b000001; mux_sel_A = 2'b01; rf_data_A = 16'hFFFF; rf_data_B = 16'h0008;
        tick();
        checkOutput("fwd01_alu_q", alu_q, 16'h0000);
        checkOutput("fwd01_zero", {15'b0, zero_flag}, 16'h0001);
        checkOutput("add_wb_data", wb_data, 16'h0008);
        mux_sel_A = 2'b00;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d_alu_q", i), alu_q, vecs[i].exp_alu);
            checkOutput($sformatf("vec%0d_zero", i), {15'b0, zero_flag}, {15'b0, vecs[i].exp_zero});
        end

        // Load, then forward the loaded value at distances 10 and 11.
        op_dec = 6'b010100; rf_data_A = 16'h0010; imm = 16'h0004; imm_sel = 1'b1;
        tick();
        checkOutput("ld_dm_addr", dm_addr, 16'h0014);
        op_dec = 6'b000000; rf_data_A = 16'h0000; rf_data_B = 16'h0000; imm_sel = 1'b0;
        mem_mux_sel_dm = 1'b1; dm_rdata = 16'hBEEF;
        tick();
        checkOutput("ld_wb_data", wb_data, 16'hBEEF);
        mem_mux_sel_dm = 1'b0; dm_rdata = 16'h0000;
        mux_sel_A = 2'b10; rf_data_B = 16'h0001;
        tick();
        checkOutput("fwd10_alu_q", alu_q, 16'hBEF0);
        mux_sel_A = 2'b11; rf_data_B = 16'h0002;
        tick();
        checkOutput("fwd11_alu_q", alu_q, 16'hBEF1);
        mux_sel_A = 2'b00;

        // Store: forwarded B becomes write data, never the immediate.
        op_dec = 6'b010101; rf_data_A = 16'h0020; imm = 16'h0000; imm_sel = 1'b1; rf_data_B = 16'h1234;
        tick();
        mem_en_ex = 1'b1; mem_rw_ex = 1'b1;
        op_dec = 6'b000000; imm_sel = 1'b0; rf_data_A = 16'h0000; rf_data_B = 16'h0000;
        #1;
        checkOutput("st_dm_addr", dm_addr, 16'h0020);
        checkOutput("st_dm_wdata", dm_wdata, 16'h1234);
        checkOutput("st_dm_en", {15'b0, dm_en}, 16'h0001);
        checkOutput("st_dm_rw", {15'b0, dm_rw}, 16'h0001);
        mem_en_ex = 1'b0; mem_rw_ex = 1'b0;
        tick();

        // Same store, with reset asserted in the memory cycle.
        op_dec = 6'b010101; rf_data_A = 16'h0020; imm = 16'h0000; imm_sel = 1'b1; rf_data_B = 16'h1234;
        tick();
        mem_en_ex = 1'b1; mem_rw_ex = 1'b1; reset = 1'b0;
        #1;
        checkOutput("strst_dm_en", {15'b0, dm_en}, 16'h0000);
        checkOutput("strst_dm_rw", {15'b0, dm_rw}, 16'h0000);
        tick();
        checkOutput("strst_alu_q", alu_q, 16'h0000);
        checkOutput("strst_mem_q", wb_data, 16'h0000);
        checkOutput("strst_dm_wdata", dm_wdata, 16'h0000);
        reset = 1'b1; mem_en_ex = 1'b0; mem_rw_ex = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_forward_stage.md
# ex_forward_stage

Execute/forwarding datapath stage of the 16-bit pipelined core. It consumes the per-instruction control emitted by the data-dependency (hazard) block: decoded opcode, immediate, immediate select, forwarding mux selects, and data-memory control. From these it builds ALU operands, executes the operation, drives the data memory, and keeps the three-deep result history that the forwarding selects index into. It sits between the register-file read port and the register-file write port.

## Interface
- `WIDTH`, 16, datapath width; all data ports and result registers are `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- `op_dec`  in  6  decoded opcode, valid in issue cycle n.
- `imm`  in  16  immediate, valid in cycle n.
- `imm_sel`  in  1  1 = operand B is `imm`.
- `mux_sel_A`, `mux_sel_B`  in  2 each  forwarding select: 00 register file, 01 `alu_q`, 10 `mem_q`, 11 `wb_q`.
- `rf_data_A`, `rf_data_B`  in  16 each  register-file read data, valid in cycle n.
- `mem_en_ex`, `mem_rw_ex`  in  1 each  data-memory enable / write (1 = write), valid in cycle n+1.
- `mem_mux_sel_dm`  in  1  1 = `mem_q` takes `dm_rdata`, valid in cycle n+1.
- `dm_rdata`  in  16  asynchronous-read data memory output.
- `dm_addr`, `dm_wdata`  out  16 each  data-memory address / write data.
- `dm_en`, `dm_rw`  out  1 each  data-memory enable / write.
- `alu_q`  out  16  EX/MEM result register.
- `wb_data`  out  16  write-back data; aligned with the hazard block's `RW_dm`.
- `zero_flag`  out  1  registered result-is-zero flag.

## Operation
- Operand A = 4:1 mux on `mux_sel_A` over {`rf_data_A`, `alu_q`, `mem_q`, `wb_q`}.
- Forwarded B = same mux on `mux_sel_B`. Operand B = `imm_sel` ? `imm` : forwarded B.
- ALU function:
  - If `op_dec[5:4]` = 01 (load/store/jump class), the function is ADD; this is the address computation.
  - Otherwise the function is `op_dec[2:0]`: 000 ADD, 001 SUB (A − B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 shift left by B[3:0], 111 arithmetic shift right by B[3:0].
- Arithmetic is modulo 2^16. Carry and overflow are discarded.
- Opcode 000000 after reset is a harmless ADD.
- Registers:
  - `alu_q` ← ALU result.
  - `st_q` ← forwarded B, i.e. store data (never `imm`).
  - `mem_q` ← `mem_mux_sel_dm` ? `dm_rdata` : `alu_q`.
  - `wb_q` ← `mem_q`.
- `zero_flag` ← (ALU result == 0). It updates only when `op_dec[5:4]` = 00 and holds otherwise.
- Memory outputs:
  - `dm_addr` = `alu_q`; `dm_wdata` = `st_q`.
  - `dm_en` = `mem_en_ex` & `reset`; `dm_rw` = `mem_rw_ex` & `reset`.
- `wb_data` = `mem_q`.
- Reset (`reset` = 0 at a rising edge): `alu_q`, `st_q`, `mem_q`, `wb_q`, `zero_flag` all become 0. While `reset` is low, `dm_en` and `dm_rw` are 0 combinationally.
- Reset mid-pipeline discards all in-flight results; no partial write-back survives.

## Timing
- Cycle n: control and operands present, ALU evaluated combinationally.
- Edge ending cycle n: `alu_q`, `st_q`, `zero_flag` are captured.
- Cycle n+1:
  - `dm_addr`/`dm_wdata` are valid.
  - A memory write occurs at that edge when `dm_en` & `dm_rw`.
  - `dm_rdata` is sampled at that edge into `mem_q`.
- Cycle n+2: `wb_data` is valid (aligned with `RW_dm`). Cycle n+3: `wb_q` holds the value.
- Forwarding distance: select 01 means producer issued at n−1, 10 at n−2, 11 at n−3.
- The block performs no stalls or handshakes. Load-use timing is guaranteed by the hazard block; this block trusts the selects.
- The critical path is the forward mux → ALU → `alu_q`. The mux must not depend on the current-cycle ALU output (no combinational loop).

## Test plan
- Reset: drive nonzero inputs with `mem_en_ex` = 1 and `reset` = 0 for 2 cycles -> all registered outputs 0, `dm_en` = 0 throughout. Then `reset` = 1 -> normal capture on the next edge.
- Register ADD: op 000000, `rf_data_A` = 0x0003, `rf_data_B` = 0x0005, selects 00 -> `alu_q` = 0x0008 at n+1, `wb_data` = 0x0008 at n+2, `zero_flag` = 0.
- Forward 01 + zero: after the ADD above, issue SUB (op 000001) with `mux_sel_A` = 01, `rf_data_A` = 0xFFFF, `rf_data_B` = 0x0008 -> `alu_q` = 0x0000, `zero_flag` = 1.
- Immediate wrap and shift: op 001000, `imm_sel` = 1, A = 0x8000, `imm` = 0x8000 -> 0x0000. Op 001111, A = 0x8000, `imm` = 0x0004 -> 0xF800.
- Load then forward 10: op 010100, A = 0x0010, `imm` = 0x0004 -> `dm_addr` = 0x0014 at n+1. With `dm_rdata` = 0xBEEF and `mem_mux_sel_dm` = 1, `wb_data` = 0xBEEF at n+2. Next-but-one ADD with `mux_sel_A` = 10, B = 0x0001 -> 0xBEF0.
- Store + mid-pipeline reset: op 010101, A = 0x0020, `imm` = 0, forwarded B = 0x1234 -> `dm_wdata` = 0x1234, `dm_en` = `dm_rw` = 1 at n+1. Repeat with `reset` = 0 in cycle n+1 -> `dm_en` = 0, no write, `alu_q` = `mem_q` = 0 next cycle.
